// File: rtl/program_counter.sv
// Fetch program counter with START/RUN/FLUSH sequencing and a return-address stack.
// Define PC_RAS_CHECK_EN for return-stack overflow/underflow detection; otherwise the stack pointer wraps.
module program_counter #(
  parameter int unsigned           WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC     = '0,
  parameter int unsigned           RAS_DEPTH    = 8,
  parameter int unsigned           OFFSET_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctrl_valid,
  input  logic                    jump_immediate,
  input  logic                    jump_stack,
  input  logic                    branch,
  input  logic                    is_call,
  input  logic                    is_return,
  input  logic [WORD_WIDTH-1:0]   immediate,
  input  logic [WORD_WIDTH-1:0]   top,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic                    fetch_ready,
  output logic [WORD_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_valid,
  output logic                    flush,
  output logic                    ras_error
);

  // RAS_DEPTH is a power of two and at least 2, so the index wraps naturally.
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
`ifdef PC_RAS_CHECK_EN
  localparam int unsigned SP_W  = PTR_W + 1;
`else
  localparam int unsigned SP_W  = PTR_W;
`endif

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]         sp_q, sp_d;
  logic [WORD_WIDTH-1:0]   ras_mem [RAS_DEPTH];

  logic                    handshake;
  logic                    redirect;
  logic                    do_push;
  logic                    do_pop;
  logic                    push_en;
  logic [PTR_W-1:0]        push_idx;
  logic [PTR_W-1:0]        top_idx;
  logic [WORD_WIDTH-1:0]   pc_inc;
  logic [WORD_WIDTH-1:0]   branch_tgt;
  logic [WORD_WIDTH-1:0]   pop_data;
  logic [WORD_WIDTH-1:0]   target;

`ifdef PC_RAS_CHECK_EN
  logic ras_error_q, ras_error_d;
  logic ras_full;
  logic ras_empty;
`endif

  assign handshake  = (state_q == RUN) && fetch_ready;
  assign redirect   = ctrl_valid && (is_return || jump_stack || jump_immediate || branch);
  assign do_pop     = handshake && ctrl_valid && is_return;
  // A call only pushes alongside an absolute jump, and never when a return wins.
  assign do_push    = handshake && ctrl_valid && is_call && !is_return && (jump_stack || jump_immediate);

  assign pc_inc     = pc_q + WORD_WIDTH'(1);
  assign branch_tgt = pc_q + WORD_WIDTH'($signed(offset));
  assign push_idx   = sp_q[PTR_W-1:0];
  assign top_idx    = PTR_W'(sp_q - SP_W'(1));

`ifdef PC_RAS_CHECK_EN
  assign ras_full   = (sp_q == SP_W'(RAS_DEPTH));
  assign ras_empty  = (sp_q == '0);
  assign pop_data   = ras_empty ? '0 : ras_mem[top_idx];
`else
  assign pop_data   = ras_mem[top_idx];
`endif

  always_comb begin
    if (is_return) begin
      target = pop_data;
    end else if (jump_stack) begin
      target = top;
    end else if (jump_immediate) begin
      target = immediate;
    end else begin
      target = branch_tgt;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push_en = 1'b0;
`ifdef PC_RAS_CHECK_EN
    ras_error_d = ras_error_q;
`endif

    unique case (state_q)
      START: state_d = RUN;
      RUN: begin
        if (handshake) begin
          if (redirect) begin
            pc_d    = target;
            state_d = FLUSH;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = START;
    endcase

`ifdef PC_RAS_CHECK_EN
    if (do_pop) begin
      if (ras_empty) begin
        ras_error_d = 1'b1;
      end else begin
        sp_d = sp_q - SP_W'(1);
      end
    end else if (do_push) begin
      if (ras_full) begin
        ras_error_d = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_W'(1);
      end
    end
`else
    if (do_pop) begin
      sp_d = sp_q - SP_W'(1);
    end else if (do_push) begin
      push_en = 1'b1;
      sp_d    = sp_q + SP_W'(1);
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= START;
      pc_q    <= RESET_PC;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
    end
  end

  // NOTE: the stack storage has no reset; clearing the pointer is enough to
  // make its stale contents unreachable as valid entries.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[push_idx] <= pc_inc;
    end
  end

`ifdef PC_RAS_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_error_q <= 1'b0;
    end else begin
      ras_error_q <= ras_error_d;
    end
  end

  assign ras_error = ras_error_q;
`else
  assign ras_error = 1'b0;
`endif

  assign fetch_addr  = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign flush       = (state_q == FLUSH);

endmodule
